// File: rtl/id_ex_stage.sv
// Decode stage and ID/EX pipeline register of the 5-stage MIPS pipeline.
// Decodes the IF/ID word, inserts load-use bubbles and applies EX branch flushes.
module id_ex_stage #(
  parameter int PC_W           = 32,
  parameter bit ILLEGAL_AS_NOP = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     id_instr,
  input  logic [PC_W-1:0] id_pc4,
  input  logic            id_valid,
  input  logic            flush,
  output logic [4:0]      rf_rs_num,
  output logic [4:0]      rf_rt_num,
  input  logic [31:0]     rf_rs_data,
  input  logic [31:0]     rf_rt_data,
  output logic            stall,
  output logic            ex_valid,
  output logic [PC_W-1:0] ex_pc4,
  output logic [31:0]     ex_rs_data,
  output logic [31:0]     ex_rt_data,
  output logic [31:0]     ex_imm,
  output logic [4:0]      ex_rs,
  output logic [4:0]      ex_rt,
  output logic [4:0]      ex_dest,
  output logic [2:0]      ex_alu_op,
  output logic            ex_alu_src,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_mem_to_reg,
  output logic            ex_beq,
  output logic            ex_bne,
  output logic            ex_illegal
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;
  localparam logic [2:0] ALU_LUI = 3'd5;

  typedef enum logic [1:0] {EXT_SIGN = 2'd0, EXT_ZERO = 2'd1, EXT_HIGH = 2'd2} ext_e;

  typedef struct packed {
    logic            valid;
    logic [PC_W-1:0] pc4;
    logic [31:0]     rs_data;
    logic [31:0]     rt_data;
    logic [31:0]     imm;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      dest;
    logic [2:0]      alu_op;
    logic            alu_src;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            mem_to_reg;
    logic            beq;
    logic            bne;
    logic            illegal;
  } ex_reg_t;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm16;

  logic [2:0]  dec_alu_op;
  logic        dec_alu_src;
  logic        dec_writes;
  logic        dec_dest_is_rd;
  logic        dec_mem_read;
  logic        dec_mem_write;
  logic        dec_mem_to_reg;
  logic        dec_beq;
  logic        dec_bne;
  logic        dec_illegal;
  ext_e        dec_ext;
  logic        uses_rs;
  logic        uses_rt;

  logic [4:0]  dest;
  logic [31:0] imm_ext;
  logic        hazard;
  logic        bubble;
  ex_reg_t     ex_d;
  ex_reg_t     ex_q;

  assign opcode    = id_instr[31:26];
  assign rs        = id_instr[25:21];
  assign rt        = id_instr[20:16];
  assign rd        = id_instr[15:11];
  assign imm16     = id_instr[15:0];
  assign funct     = id_instr[5:0];
  assign rf_rs_num = rs;
  assign rf_rt_num = rt;

  // Instruction decode: control, immediate kind and which source registers are read.
  always_comb begin
    dec_alu_op     = ALU_ADD;
    dec_alu_src    = 1'b0;
    dec_writes     = 1'b0;
    dec_dest_is_rd = 1'b0;
    dec_mem_read   = 1'b0;
    dec_mem_write  = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_beq        = 1'b0;
    dec_bne        = 1'b0;
    dec_illegal    = 1'b0;
    dec_ext        = EXT_SIGN;
    uses_rs        = 1'b0;
    uses_rt        = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        // The all-zero word is the canonical NOP: decodes to nothing, not illegal.
        if (id_instr == 32'h0000_0000) begin
          dec_illegal = 1'b0;
        end else begin
          dec_writes     = 1'b1;
          dec_dest_is_rd = 1'b1;
          uses_rs        = 1'b1;
          uses_rt        = 1'b1;
          case (funct)
            FN_ADD:  dec_alu_op = ALU_ADD;
            FN_SUB:  dec_alu_op = ALU_SUB;
            FN_AND:  dec_alu_op = ALU_AND;
            FN_OR:   dec_alu_op = ALU_OR;
            FN_SLT:  dec_alu_op = ALU_SLT;
            default: begin
              dec_illegal    = 1'b1;
              dec_writes     = 1'b0;
              dec_dest_is_rd = 1'b0;
              uses_rs        = 1'b0;
              uses_rt        = 1'b0;
            end
          endcase
        end
      end
      OP_ADDI: begin
        dec_alu_src = 1'b1; dec_writes = 1'b1; uses_rs = 1'b1;
      end
      OP_SLTI: begin
        dec_alu_op = ALU_SLT; dec_alu_src = 1'b1; dec_writes = 1'b1; uses_rs = 1'b1;
      end
      OP_ANDI: begin
        dec_alu_op = ALU_AND; dec_alu_src = 1'b1; dec_writes = 1'b1; uses_rs = 1'b1;
        dec_ext    = EXT_ZERO;
      end
      OP_ORI: begin
        dec_alu_op = ALU_OR; dec_alu_src = 1'b1; dec_writes = 1'b1; uses_rs = 1'b1;
        dec_ext    = EXT_ZERO;
      end
      OP_LUI: begin
        dec_alu_op = ALU_LUI; dec_alu_src = 1'b1; dec_writes = 1'b1;
        dec_ext    = EXT_HIGH;
      end
      OP_LW: begin
        dec_alu_src = 1'b1; dec_writes = 1'b1; dec_mem_read = 1'b1;
        dec_mem_to_reg = 1'b1; uses_rs = 1'b1;
      end
      OP_SW: begin
        dec_alu_src = 1'b1; dec_mem_write = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1;
      end
      OP_BEQ: begin
        dec_alu_op = ALU_SUB; dec_beq = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1;
      end
      OP_BNE: begin
        dec_alu_op = ALU_SUB; dec_bne = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // Destination register and immediate extension.
  always_comb begin
    if (dec_writes) begin
      if (dec_dest_is_rd) begin
        dest = rd;
      end else begin
        dest = rt;
      end
    end else begin
      dest = 5'd0;
    end
    case (dec_ext)
      EXT_SIGN: imm_ext = {{16{imm16[15]}}, imm16};
      EXT_ZERO: imm_ext = {16'h0000, imm16};
      EXT_HIGH: imm_ext = {imm16, 16'h0000};
      default:  imm_ext = {{16{imm16[15]}}, imm16};
    endcase
  end

  assign hazard = ex_q.valid & ex_q.mem_read & (ex_q.dest != 5'd0) & id_valid &
                  ((uses_rs & (ex_q.dest == rs)) | (uses_rt & (ex_q.dest == rt)));
  // A flush kills the ID instruction anyway, so holding IF/ID for it would be wasted.
  assign stall  = hazard & ~flush;

  // Next ID/EX contents: flush, hazard, empty slot or dropped illegal all load a bubble.
  always_comb begin
    ex_d   = '0;
    bubble = flush | hazard | ~id_valid | (dec_illegal & ~ILLEGAL_AS_NOP);
    if (bubble) begin
      ex_d = '0;
    end else begin
      ex_d.valid      = 1'b1;
      ex_d.pc4        = id_pc4;
      ex_d.rs_data    = rf_rs_data;
      ex_d.rt_data    = rf_rt_data;
      ex_d.imm        = imm_ext;
      ex_d.rs         = rs;
      ex_d.rt         = rt;
      ex_d.dest       = dest;
      ex_d.alu_op     = dec_alu_op;
      ex_d.alu_src    = dec_alu_src;
      ex_d.reg_write  = dec_writes & (dest != 5'd0);
      ex_d.mem_read   = dec_mem_read;
      ex_d.mem_write  = dec_mem_write;
      ex_d.mem_to_reg = dec_mem_to_reg;
      ex_d.beq        = dec_beq;
      ex_d.bne        = dec_bne;
      ex_d.illegal    = dec_illegal;
    end
  end

  // ID/EX pipeline register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign ex_valid      = ex_q.valid;
  assign ex_pc4        = ex_q.pc4;
  assign ex_rs_data    = ex_q.rs_data;
  assign ex_rt_data    = ex_q.rt_data;
  assign ex_imm        = ex_q.imm;
  assign ex_rs         = ex_q.rs;
  assign ex_rt         = ex_q.rt;
  assign ex_dest       = ex_q.dest;
  assign ex_alu_op     = ex_q.alu_op;
  assign ex_alu_src    = ex_q.alu_src;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_mem_to_reg = ex_q.mem_to_reg;
  assign ex_beq        = ex_q.beq;
  assign ex_bne        = ex_q.bne;
  assign ex_illegal    = ex_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: decode vector table, hand-written hazard/flush/reset
// sequences, and a randomized run against a table-based reference model.
module tb_id_ex_stage;

  localparam int PC_W = 32;

  logic            clk;
  logic            reset;
  logic [31:0]     id_instr;
  logic [PC_W-1:0] id_pc4;
  logic            id_valid;
  logic            flush;
  logic [4:0]      rf_rs_num, rf_rt_num;
  logic [31:0]     rf_rs_data, rf_rt_data;
  logic            stall, ex_valid;
  logic [PC_W-1:0] ex_pc4;
  logic [31:0]     ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]      ex_rs, ex_rt, ex_dest;
  logic [2:0]      ex_alu_op;
  logic ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic ex_beq, ex_bne, ex_illegal;

  id_ex_stage #(.PC_W(PC_W), .ILLEGAL_AS_NOP(1'b1)) dut (
    .clk(clk), .reset(reset), .id_instr(id_instr), .id_pc4(id_pc4), .id_valid(id_valid),
    .flush(flush), .rf_rs_num(rf_rs_num), .rf_rt_num(rf_rt_num), .rf_rs_data(rf_rs_data),
    .rf_rt_data(rf_rt_data), .stall(stall), .ex_valid(ex_valid), .ex_pc4(ex_pc4),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_rs(ex_rs),
    .ex_rt(ex_rt), .ex_dest(ex_dest), .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_beq(ex_beq), .ex_bne(ex_bne), .ex_illegal(ex_illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ctl = {alu_src, reg_write, mem_read, mem_write, mem_to_reg, beq, bne, illegal}
  typedef struct packed {
    logic        valid;
    logic [31:0] pc4;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic [2:0]  alu;
    logic [7:0]  ctl;
  } ex_t;

  ex_t act;
  logic [7:0] ctl_act;
  assign ctl_act = {ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
                    ex_beq, ex_bne, ex_illegal};
  assign act = {ex_valid, ex_pc4, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_dest,
                ex_alu_op, ctl_act};

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [159:0] a, input logic [159:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, a, e);
    end
  endtask

  // ---------------- reference model: instruction kinds and their properties -------------
  typedef enum int {K_NOP = 0, K_ADD, K_SUB, K_AND, K_OR, K_SLT, K_ADDI, K_SLTI, K_ANDI,
                    K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_BNE, K_ILL} kind_e;

  // flags = {src, writes, dest_is_rd, mem_read, mem_write, mem_to_reg, beq, bne, illegal}
  // ext: 0 sign, 1 zero, 2 upper half; uses = {rs, rt}
  typedef struct packed {
    logic [2:0] alu;
    logic [8:0] flags;
    logic [1:0] ext;
    logic [1:0] uses;
  } prop_t;

  prop_t props [16];

  function automatic kind_e classify(input logic [31:0] w);
    if (w == 32'd0) return K_NOP;
    case (w[31:26])
      6'h00: case (w[5:0])
               6'h20: return K_ADD;
               6'h22: return K_SUB;
               6'h24: return K_AND;
               6'h25: return K_OR;
               6'h2A: return K_SLT;
               default: return K_ILL;
             endcase
      6'h08: return K_ADDI;
      6'h0A: return K_SLTI;
      6'h0C: return K_ANDI;
      6'h0D: return K_ORI;
      6'h0F: return K_LUI;
      6'h23: return K_LW;
      6'h2B: return K_SW;
      6'h04: return K_BEQ;
      6'h05: return K_BNE;
      default: return K_ILL;
    endcase
  endfunction

  function automatic logic [31:0] build(input kind_e k, input logic [4:0] s, input logic [4:0] t,
                                        input logic [4:0] d, input logic [15:0] im);
    case (k)
      K_ADD:  return {6'h00, s, t, d, 5'd0, 6'h20};
      K_SUB:  return {6'h00, s, t, d, 5'd0, 6'h22};
      K_AND:  return {6'h00, s, t, d, 5'd0, 6'h24};
      K_OR:   return {6'h00, s, t, d, 5'd0, 6'h25};
      K_SLT:  return {6'h00, s, t, d, 5'd0, 6'h2A};
      K_ADDI: return {6'h08, s, t, im};
      K_SLTI: return {6'h0A, s, t, im};
      K_ANDI: return {6'h0C, s, t, im};
      K_ORI:  return {6'h0D, s, t, im};
      K_LUI:  return {6'h0F, s, t, im};
      K_LW:   return {6'h23, s, t, im};
      K_SW:   return {6'h2B, s, t, im};
      K_BEQ:  return {6'h04, s, t, im};
      K_BNE:  return {6'h05, s, t, im};
      K_ILL:  return im[0] ? {6'h3F, s, t, im} : {6'h00, s, t, d, 5'd1, 6'h3F};
      default: return 32'd0;
    endcase
  endfunction

  function automatic ex_t model(input ex_t cur, input logic [31:0] w, input logic [31:0] pc,
                                input logic v, input logic fl, input logic [31:0] a,
                                input logic [31:0] b, output logic stl);
    prop_t p;
    ex_t n;
    logic hz;
    logic [4:0] s, t, d;
    p = props[classify(w)];
    s = w[25:21];
    t = w[20:16];
    d = w[15:11];
    hz = cur.valid && cur.ctl[5] && (cur.dest != 5'd0) && v &&
         ((p.uses[1] && cur.dest == s) || (p.uses[0] && cur.dest == t));
    stl = hz && !fl;
    n = '0;
    if (v && !fl && !hz) begin
      n.valid   = 1'b1;
      n.pc4     = pc;
      n.rs_data = a;
      n.rt_data = b;
      n.rs      = s;
      n.rt      = t;
      n.alu     = p.alu;
      if (p.ext == 2'd1)      n.imm = {16'd0, w[15:0]};
      else if (p.ext == 2'd2) n.imm = {w[15:0], 16'd0};
      else                    n.imm = {{16{w[15]}}, w[15:0]};
      n.dest = p.flags[7] ? (p.flags[6] ? d : t) : 5'd0;
      n.ctl  = {p.flags[8], p.flags[7] && (n.dest != 5'd0), p.flags[5:0]};
    end
    return n;
  endfunction

  // ---------------- decode vector table ----------------
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic        valid;
    logic [2:0]  alu;
    logic [31:0] imm;
    logic [4:0]  dest;
    logic [7:0]  ctl;
  } vec_t;

  vec_t vecs [18];

  task automatic drive(input logic [31:0] w, input logic [31:0] pc, input logic v,
                       input logic fl, input logic [31:0] a, input logic [31:0] b);
    id_instr = w; id_pc4 = pc; id_valid = v; flush = fl; rf_rs_data = a; rf_rt_data = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] ins, ra, rb, pc;
  logic        rv, rfl, stl, hold;
  kind_e       k;
  ex_t         mexp, nexp;

  initial begin
    props[K_NOP]  = {3'd0, 9'b000000000, 2'd0, 2'b00};
    props[K_ADD]  = {3'd0, 9'b011000000, 2'd0, 2'b11};
    props[K_SUB]  = {3'd1, 9'b011000000, 2'd0, 2'b11};
    props[K_AND]  = {3'd2, 9'b011000000, 2'd0, 2'b11};
    props[K_OR]   = {3'd3, 9'b011000000, 2'd0, 2'b11};
    props[K_SLT]  = {3'd4, 9'b011000000, 2'd0, 2'b11};
    props[K_ADDI] = {3'd0, 9'b110000000, 2'd0, 2'b10};
    props[K_SLTI] = {3'd4, 9'b110000000, 2'd0, 2'b10};
    props[K_ANDI] = {3'd2, 9'b110000000, 2'd1, 2'b10};
    props[K_ORI]  = {3'd3, 9'b110000000, 2'd1, 2'b10};
    props[K_LUI]  = {3'd5, 9'b110000000, 2'd2, 2'b00};
    props[K_LW]   = {3'd0, 9'b110101000, 2'd0, 2'b10};
    props[K_SW]   = {3'd0, 9'b100010000, 2'd0, 2'b11};
    props[K_BEQ]  = {3'd1, 9'b000000100, 2'd0, 2'b11};
    props[K_BNE]  = {3'd1, 9'b000000010, 2'd0, 2'b11};
    props[K_ILL]  = {3'd0, 9'b000000001, 2'd0, 2'b00};

    vecs[0]  = {32'h00221820, 32'd5,        32'd7,        1'b1, 3'd0, 32'h00001820, 5'd3,  8'h40};
    vecs[1]  = {32'h01093822, 32'h11111111, 32'h22222222, 1'b1, 3'd1, 32'h00003822, 5'd7,  8'h40};
    vecs[2]  = {32'h016C5024, 32'hDEADBEEF, 32'h0F0F0F0F, 1'b1, 3'd2, 32'h00005024, 5'd10, 8'h40};
    vecs[3]  = {32'h00430825, 32'h00000001, 32'h80000000, 1'b1, 3'd3, 32'h00000825, 5'd1,  8'h40};
    vecs[4]  = {32'h00A6202A, 32'hFFFFFFFF, 32'h00000002, 1'b1, 3'd4, 32'h0000202A, 5'd4,  8'h40};
    vecs[5]  = {32'h00220020, 32'd3,        32'd4,        1'b1, 3'd0, 32'h00000020, 5'd0,  8'h00};
    vecs[6]  = {32'h2006FFFF, 32'd0,        32'd9,        1'b1, 3'd0, 32'hFFFFFFFF, 5'd6,  8'hC0};
    vecs[7]  = {32'h2826FFFE, 32'd8,        32'd9,        1'b1, 3'd4, 32'hFFFFFFFE, 5'd6,  8'hC0};
    vecs[8]  = {32'h30278000, 32'd1,        32'd2,        1'b1, 3'd2, 32'h00008000, 5'd7,  8'hC0};
    vecs[9]  = {32'h3406FFFF, 32'd0,        32'd5,        1'b1, 3'd3, 32'h0000FFFF, 5'd6,  8'hC0};
    vecs[10] = {32'h3C061234, 32'd6,        32'd7,        1'b1, 3'd5, 32'h12340000, 5'd6,  8'hC0};
    vecs[11] = {32'h8C240008, 32'h1000,     32'd0,        1'b1, 3'd0, 32'h00000008, 5'd4,  8'hE8};
    vecs[12] = {32'h1022FFFC, 32'd5,        32'd5,        1'b1, 3'd1, 32'hFFFFFFFC, 5'd0,  8'h04};
    vecs[13] = {32'h14640010, 32'd1,        32'd2,        1'b1, 3'd1, 32'h00000010, 5'd0,  8'h02};
    vecs[14] = {32'hAC24000C, 32'h2000,     32'hCAFE,     1'b1, 3'd0, 32'h0000000C, 5'd0,  8'h90};
    vecs[15] = {32'hFC000000, 32'd1,        32'd2,        1'b1, 3'd0, 32'h00000000, 5'd0,  8'h01};
    vecs[16] = {32'h00000000, 32'd0,        32'd0,        1'b1, 3'd0, 32'h00000000, 5'd0,  8'h00};
    vecs[17] = {32'h0022183F, 32'd4,        32'd4,        1'b1, 3'd0, 32'h0000183F, 5'd0,  8'h01};

    // Reset at time zero, then release between edges.
    reset = 1'b1;
    drive(32'h00221820, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    #1 reset = 1'b0;
    #2;
    check("reset_state", {act, stall}, 160'd0);
    check("rf_nums", {rf_rs_num, rf_rt_num}, {5'd1, 5'd2});
    #9 reset = 1'b1;

    for (int i = 0; i < 18; i++) begin
      pc = 32'h0040_0000 + 32'(i) * 32'd4;
      drive(vecs[i].instr, pc, 1'b1, 1'b0, vecs[i].a, vecs[i].b);
      tick();
      check($sformatf("vec%0d", i),
            {ex_valid, ex_pc4, ex_rs_data, ex_rt_data, ex_imm, ex_dest, ex_alu_op, ctl_act},
            {vecs[i].valid, pc, vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].dest,
             vecs[i].alu, vecs[i].ctl});
    end

    // lw $4,8($1) ; add $5,$4,$2 -> one stall cycle and one bubble.
    drive(32'h8C240008, 32'h100, 1'b1, 1'b0, 32'd1, 32'd2);
    tick();
    drive(32'h00822820, 32'h104, 1'b1, 1'b0, 32'd9, 32'd10);
    #1 check("lu_stall", stall, 1'b1);
    tick();
    check("lu_bubble", act, 160'd0);
    check("lu_release", stall, 1'b0);
    tick();
    check("lu_issue", {ex_valid, ex_dest, ex_alu_op, ex_reg_write, ex_rs_data, ex_rt_data},
          {1'b1, 5'd5, 3'd0, 1'b1, 32'd9, 32'd10});

    // lw $0 followed by a use of $0 -> no stall.
    drive(32'h8C200004, 32'h108, 1'b1, 1'b0, 32'd1, 32'd2);
    tick();
    check("lw0_ctl", {ex_valid, ex_reg_write, ex_mem_read, ex_dest}, {1'b1, 1'b0, 1'b1, 5'd0});
    drive(32'h00022820, 32'h10C, 1'b1, 1'b0, 32'd0, 32'd3);
    #1 check("lw0_nostall", stall, 1'b0);
    tick();
    check("lw0_issue", {ex_valid, ex_dest}, {1'b1, 5'd5});

    // Hazard and flush together -> flush wins.
    drive(32'h8C240008, 32'h110, 1'b1, 1'b0, 32'd1, 32'd2);
    tick();
    drive(32'h00822820, 32'h114, 1'b1, 1'b1, 32'd9, 32'd10);
    #1 check("hf_stall", stall, 1'b0);
    tick();
    check("hf_bubble", act, 160'd0);

    // Illegal opcode pulses ex_illegal for one slot only.
    drive(32'hFC000000, 32'h118, 1'b1, 1'b0, 32'd0, 32'd0);
    tick();
    check("ill_pulse", {ex_valid, ctl_act}, {1'b1, 8'h01});
    drive(32'h00000000, 32'h11C, 1'b1, 1'b0, 32'd0, 32'd0);
    tick();
    check("ill_clear", {ex_valid, ex_illegal}, {1'b1, 1'b0});

    // id_valid low -> bubble.
    drive(32'h00221820, 32'h120, 1'b0, 1'b0, 32'd5, 32'd7);
    tick();
    check("invalid_bubble", act, 160'd0);

    // Asynchronous reset in the middle of a stall.
    drive(32'h8C240008, 32'h124, 1'b1, 1'b0, 32'd1, 32'd2);
    tick();
    drive(32'h00822820, 32'h128, 1'b1, 1'b0, 32'd9, 32'd10);
    #1 check("pre_reset_stall", stall, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("async_reset_ex", act, 160'd0);
    check("async_reset_stall", stall, 1'b0);
    #1 reset = 1'b1;
    tick();
    check("post_reset_load", {ex_valid, ex_dest, ex_pc4}, {1'b1, 5'd5, 32'h128});

    // Randomized run against the reference model, starting from an empty ID/EX.
    drive(32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    mexp = '0;
    check("rnd_start", act, mexp);
    hold = 1'b0;
    ins = 32'd0;
    for (int n = 0; n < 2000; n++) begin
      if (!hold) begin
        k   = kind_e'($urandom_range(0, 15));
        ins = build(k, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), 16'($urandom));
      end
      ra  = $urandom;
      rb  = $urandom;
      pc  = $urandom;
      rv  = ($urandom_range(0, 9) != 0);
      rfl = ($urandom_range(0, 7) == 0);
      drive(ins, pc, rv, rfl, ra, rb);
      #1;
      nexp = model(mexp, ins, pc, rv, rfl, ra, rb, stl);
      check("rnd_stall", stall, stl);
      check("rnd_rfnum", {rf_rs_num, rf_rt_num}, {ins[25:21], ins[20:16]});
      tick();
      check("rnd_ex", act, nexp);
      mexp = nexp;
      hold = stl;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
